lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Multi-cycle load/store port between the execute stage and a handshaked data memory.
- Produces the ReadData word consumed by the ResultSrc=01 input of the writeback result mux.
- Holds the core with `stall` while a bus transaction is outstanding.
- Handles byte/half/word access sizes: byte enables, store lane replication, load sign/zero extension, misalignment and timeout errors.

Parameters:
- width, 32: data/address width; byte-lane logic is defined for 32 only.
- TIMEOUT, 16: maximum REQ cycles waiting for mem_ack before aborting; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead  in  1  load instruction in execute.
- MemWrite  in  1  store instruction in execute.
- funct3  in  3  access size/sign (RV32I encoding).
- ALUResult  in  width  byte address.
- WriteData  in  width  store data (rs2).
- ReadData  out  width  extended load result to result mux.
- stall  out  1  freeze PC/pipeline.
- err  out  1  sticky error: misaligned, illegal funct3 or timeout.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  width  word-aligned address ({ALUResult[width-1:2],2'b00}).
- mem_be  out  4  byte enables.
- mem_wdata  out  width  lane-replicated store data.
- mem_rdata  in  width  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ReadData=0; err=0; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0; timeout counter=0.
  - Reset mid-transaction abandons it; mem_req drops immediately.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If (MemRead|MemWrite) and access legal: stall=1 combinationally in the same cycle. Next edge goes to REQ and registers mem_addr, mem_we (=MemWrite), mem_be, mem_wdata, funct3 and ALUResult[1:0].
  - If the access is illegal: err<=1, no bus activity, go to DONE, ReadData<=0.
  - Otherwise: stall=0.
  - MemRead and MemWrite both high: treated as a write.
- REQ:
  - mem_req=1; all mem_* outputs stable until ack; stall=1; counter increments each cycle.
  - mem_ack=1: go to DONE. For a read, ReadData<=extend(mem_rdata lane); for a write, ReadData is unchanged.
  - counter reaches TIMEOUT-1 without ack: err<=1, ReadData<=0, go to DONE, mem_req drops. A later mem_ack is ignored.
- DONE:
  - stall=0 for exactly one cycle (the instruction retires at this edge); mem_req=0; go to IDLE.
- Latency: single-cycle ack gives 3 cycles from instruction presentation to retirement (IDLE, REQ, DONE).
- Access sizes:
  - Legality: byte any address; half requires addr[0]=0; word requires addr[1:0]=00.
  - Loads: funct3 011/110/111 illegal.
  - Stores: only 000/001/010 legal.
- Byte enables:
  - SB: 0001<<addr[1:0].
  - SH: 0011<<addr[1:0].
  - SW: 1111.
  - Loads use the same masks.
- mem_wdata:
  - SB: byte replicated 4x.
  - SH: half replicated 2x.
  - SW: as-is.
- Load extension:
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend the selected lane.
  - LW: full word.
- ReadData holds its value until the next completed load (or the next error).
- err stays set until reset.

Decomposition:
- Shared package (e.g. riscv_pkg): funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encoding, byte-enable width constant.
- One natural sub-module, lsu_load_align: combinational lane select plus sign/zero extension from (mem_rdata, addr[1:0], funct3).

Test Plan:
- LW at 0x100, rdata=0xDEADBEEF, ack in the 2nd REQ cycle -> mem_addr=0x100, be=1111, stall high 3 cycles, ReadData=0xDEADBEEF, err=0.
- LB at 0x103, rdata=0x80xxxxxx, then LBU at the same address -> be=1000; ReadData=0xFFFFFF80 then 0x00000080.
- SH at 0x202, WriteData=0x1234ABCD -> mem_we=1, addr=0x200, be=1100, wdata=0xABCDABCD; ReadData unchanged.
- LH at 0x101 (misaligned) -> no mem_req ever, err=1, stall high 1 cycle, ReadData=0.
- LW with no ack, TIMEOUT=16 -> mem_req high 16 cycles then low, err=1, ReadData=0; a late ack has no effect.
- rst_n pulsed low during REQ -> mem_req, stall and err drop immediately; state IDLE after release; a new LW completes normally.

Source files
------------

// File: rtl/lsu_mem_port_pkg.sv
// +--------------------------------------------------------------------+
// | lsu_mem_port_pkg: shared funct3 codes, FSM states, access helpers  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package lsu_mem_port_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Loads and stores share the same lane mask; only the size bits matter.
  function automatic logic [BE_W-1:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << lo;
      2'b01:   byte_en = 4'b0011 << lo;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic f3_ok;
    logic align_ok;
    if (is_store) f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else          f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                          (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      2'b01:   align_ok = (lo[0] == 1'b0);
      2'b10:   align_ok = (lo == 2'b00);
      default: align_ok = 1'b1;
    endcase
    access_legal = f3_ok && align_ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// +--------------------------------------------------------------------+
// | lsu_load_align: lane select and sign/zero extension of load data   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_load_align
  import lsu_mem_port_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [width-1:0] mem_rdata,
  input  logic [1:0]       addr_lo,
  input  logic [2:0]       funct3,
  output logic [width-1:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem_rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{(width-8){byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {{(width-8){1'b0}}, byte_lane};
      F3_H:    load_data = {{(width-16){half_lane[15]}}, half_lane};
      F3_HU:   load_data = {{(width-16){1'b0}}, half_lane};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_port.sv
// +--------------------------------------------------------------------+
// | lsu_mem_port: multi-cycle load/store port to a handshaked memory   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int width   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [width-1:0]  ALUResult,
  input  logic [width-1:0]  WriteData,
  output logic [width-1:0]  ReadData,
  output logic              stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [width-1:0]  mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [width-1:0]  mem_wdata,
  input  logic [width-1:0]  mem_rdata,
  input  logic              mem_ack
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state;
  lsu_state_e        next_state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic              access;
  logic              legal;
  logic              cnt_last;
  logic [BE_W-1:0]   be_next;
  logic [width-1:0]  wdata_next;
  logic [width-1:0]  load_data;

  assign access   = MemRead | MemWrite;
  assign legal    = access_legal(MemWrite, funct3, ALUResult[1:0]);
  assign cnt_last = (cnt == CNT_LAST);
  assign be_next  = byte_en(funct3, ALUResult[1:0]);

  always_comb begin
    case (funct3[1:0])
      2'b00:   wdata_next = {4{WriteData[7:0]}};
      2'b01:   wdata_next = {2{WriteData[15:0]}};
      default: wdata_next = WriteData;
    endcase
  end

  lsu_load_align #(
    .width (width)
  ) u_load_align (
    .mem_rdata (mem_rdata),
    .addr_lo   (lo_q),
    .funct3    (f3_q),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (access) next_state = legal ? ST_REQ : ST_DONE;
      ST_REQ:  if (mem_ack || cnt_last) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Stall is gated by rst_n so an async reset releases the pipeline at once.
  always_comb begin
    stall   = 1'b0;
    mem_req = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: stall = access;
        ST_REQ: begin
          stall   = 1'b1;
          mem_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadData  <= '0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      f3_q      <= 3'b000;
      lo_q      <= 2'b00;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (legal) begin
              mem_addr  <= {ALUResult[width-1:2], 2'b00};
              mem_we    <= MemWrite;
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
              f3_q      <= funct3;
              lo_q      <= ALUResult[1:0];
              cnt       <= '0;
            end else begin
              err      <= 1'b1;
              ReadData <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (!mem_we) ReadData <= load_data;
          end else if (cnt_last) begin
            err      <= 1'b1;
            ReadData <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// +--------------------------------------------------------------------+
// | tb_lsu_mem_port: randomized bench with a behavioural LSU model     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_lsu_mem_port;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_rd;
  logic        exp_err;

  lsu_mem_port #(
    .width   (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .stall     (stall),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference rules, expressed as access size in bytes.
  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_legal(input logic st, input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    if (st) ok = (f3 <= 3'd2);
    else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return ok && ((int'(lo) % size_bytes(f3)) == 0);
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] lo);
    int m;
    m = ((1 << size_bytes(f3)) - 1) << lo;
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = size_bytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] mask;
    int n;
    n = size_bytes(f3);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
    v = (rd >> (8*lo)) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    exp_rd = '0;
    exp_err = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int ack_at);
    logic legal;
    int   nreq;
    int   exp_req;
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = a; WriteData = wd;
    #1 check("stall_issue", {31'd0, stall}, 32'd1);
    legal = ref_legal(wr, f3, a[1:0]);
    if (legal) begin
      nreq = 0;
      @(negedge clk);
      while (mem_req === 1'b1 && nreq < TIMEOUT + 4) begin
        check("req_stall", {31'd0, stall}, 32'd1);
        check("req_addr",  mem_addr, {a[31:2], 2'b00});
        check("req_we",    {31'd0, mem_we}, {31'd0, wr});
        check("req_be",    {28'd0, mem_be}, {28'd0, ref_be(f3, a[1:0])});
        if (wr) check("req_wdata", mem_wdata, ref_wdata(f3, wd));
        if (nreq == ack_at) begin
          mem_ack = 1'b1;
          mem_rdata = rdat;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        nreq++;
      end
      exp_req = (ack_at < TIMEOUT) ? ack_at + 1 : TIMEOUT;
      check("req_cycles", nreq, exp_req);
      if (ack_at < TIMEOUT) begin
        if (!wr) exp_rd = ref_load(f3, a[1:0], rdat);
      end else begin
        exp_err = 1'b1;
        exp_rd = '0;
      end
    end else begin
      @(negedge clk);
      exp_err = 1'b1;
      exp_rd = '0;
    end
    check("done_stall", {31'd0, stall}, 32'd0);
    check("done_req",   {31'd0, mem_req}, 32'd0);
    check("done_rdata", ReadData, exp_rd);
    check("done_err",   {31'd0, err}, {31'd0, exp_err});
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'd0, stall}, 32'd0);
  endtask

  task automatic rand_op(input logic legal_only);
    int op;
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    op = $urandom_range(0, 2);
    rd = (op != 1);
    wr = (op != 0);
    a = $urandom;
    if (legal_only) begin
      if (wr) f3 = 3'($urandom_range(0, 2));
      else    f3 = 3'(($urandom_range(0, 4) > 2) ? $urandom_range(4, 5) : $urandom_range(0, 2));
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      run_op(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 4));
    end else begin
      f3 = 3'($urandom_range(0, 7));
      run_op(rd, wr, f3, a, $urandom, $urandom,
             ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 6));
    end
  endtask

  initial begin
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = '0;
    ALUResult = '0; WriteData = '0; mem_rdata = '0; mem_ack = 1'b0;
    exp_rd = '0; exp_err = 1'b0;
    #12;
    check("rst_rdata", ReadData, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_req",   {31'd0, mem_req}, 32'd0);
    check("rst_we",    {31'd0, mem_we}, 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_be",    {28'd0, mem_be}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0);
    run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0);
    run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0);
    run_op(1'b1, 1'b1, 3'b000, 32'h305, 32'h000000A5, 32'h0, 2);

    for (int i = 0; i < 150; i++) rand_op(1'b1);

    run_op(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0);

    // Reset while a load is outstanding.
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h300;
    @(negedge clk);
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req",   {31'd0, mem_req}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_err",   {31'd0, err}, 32'd0);
    MemRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd = '0;
    exp_err = 1'b0;
    @(negedge clk);
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    run_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 0);

    // Timeout followed by a stray ack.
    run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 99);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_rdata", ReadData, 32'd0);
    check("late_ack_err",   {31'd0, err}, 32'd1);
    check("late_ack_req",   {31'd0, mem_req}, 32'd0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) do_reset();
      rand_op(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
